// File: rtl/ocs_pkg.sv
// Shared definitions for the two-slot optical circuit switch fabric.
// Both the OCS crossbar and the per-ToR slot controller import this package,
// so the slot-to-peer map has a single source of truth.
//   TOR_NUM / SLOT_NUM      : fabric dimensions
//   slot_state_e            : slot controller sequencing states
//   RX_OFS* / TX_OFS*       : per-slot peer offsets (peer = (id + ofs) % TOR_NUM)
//   peer_of()               : peer index helper
package ocs_pkg;

    localparam int unsigned TOR_NUM  = 8;
    localparam int unsigned SLOT_NUM = 2;
    localparam int unsigned PEER_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TAIL   = 2'd3
    } slot_state_e;

    localparam logic [PEER_W-1:0] RX_OFS0 = 3'd1;
    localparam logic [PEER_W-1:0] RX_OFS1 = 3'd3;
    localparam logic [PEER_W-1:0] TX_OFS0 = 3'd7;
    localparam logic [PEER_W-1:0] TX_OFS1 = 3'd5;

    function automatic logic [PEER_W-1:0] peer_of(input logic [PEER_W-1:0] tor,
                                                 input logic [PEER_W-1:0] ofs);
        int unsigned sum;
        sum = 32'(tor) + 32'(ofs);
        return PEER_W'(sum % TOR_NUM);
    endfunction

endpackage

// File: rtl/ocs_slot_ctrl_if.sv
// Control/status bundle between a ToR slot controller and its consumers
// (local MAC and the OCS slot input).
//   i_enable, i_resync : fabric-wide sequencing controls into the controller
//   o_slot_id          : current slot, drives the OCS
//   o_slot_start       : one-cycle pulse on the first cycle of each slot
//   o_guard, o_tx_en   : transmit window qualifiers for the MAC
//   o_tx_peer/o_rx_peer: peers of this ToR in the current slot
//   o_epoch            : completed slot pairs, wraps modulo 2^16
// master = slot controller, slave = MAC/OCS side.
interface ocs_slot_ctrl_if;

    logic        i_enable;
    logic        i_resync;
    logic        o_slot_id;
    logic        o_slot_start;
    logic        o_guard;
    logic        o_tx_en;
    logic [2:0]  o_tx_peer;
    logic [2:0]  o_rx_peer;
    logic [15:0] o_epoch;

    modport master (
        input  i_enable,
        input  i_resync,
        output o_slot_id,
        output o_slot_start,
        output o_guard,
        output o_tx_en,
        output o_tx_peer,
        output o_rx_peer,
        output o_epoch
    );

    modport slave (
        output i_enable,
        output i_resync,
        input  o_slot_id,
        input  o_slot_start,
        input  o_guard,
        input  o_tx_en,
        input  o_tx_peer,
        input  o_rx_peer,
        input  o_epoch
    );

endinterface

// File: rtl/ocs_peer_map.sv
// Combinational slot/ToR -> peer lookup, shared with the OCS crossbar map.
//   slot_id_i : slot being decoded
//   tor_id_i  : local ToR index
//   tx_peer_o : ToR receiving this ToR's transmission in that slot
//   rx_peer_o : ToR whose transmission this ToR receives in that slot
module ocs_peer_map
    import ocs_pkg::*;
(
    input  logic              slot_id_i,
    input  logic [PEER_W-1:0] tor_id_i,
    output logic [PEER_W-1:0] tx_peer_o,
    output logic [PEER_W-1:0] rx_peer_o
);

    always_comb begin
        tx_peer_o = peer_of(tor_id_i, slot_id_i ? TX_OFS1 : TX_OFS0);
        rx_peer_o = peer_of(tor_id_i, slot_id_i ? RX_OFS1 : RX_OFS0);
    end

endmodule

// File: rtl/ocs_slot_ctrl.sv
// ToR-side slot controller for the two-slot OCS fabric. Sequences slots of
// P_SLOT_CYCLES cycles (head guard, active window, tail drain) and publishes
// the slot id, transmit qualifiers, peers and epoch count. All outputs are
// registered and decoded from the next-state counter, so they line up with
// the counter value with no extra latency.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   bus     : master side of ocs_slot_ctrl_if (enable/resync in, status out)
module ocs_slot_ctrl
    import ocs_pkg::*;
#(
    parameter int unsigned P_TOR_ID       = 0,
    parameter int unsigned P_TOR_NUM      = 8,
    parameter int unsigned P_SLOT_CYCLES  = 1000,
    parameter int unsigned P_GUARD_CYCLES = 50,
    parameter int unsigned P_TAIL_CYCLES  = 20,
    parameter int unsigned P_CNT_W        = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ocs_slot_ctrl_if.master bus
);

    localparam logic [PEER_W-1:0]  LP_TOR_ID    = PEER_W'(P_TOR_ID % P_TOR_NUM);
    localparam logic [P_CNT_W-1:0] LP_GUARD_END = P_CNT_W'(P_GUARD_CYCLES);
    localparam logic [P_CNT_W-1:0] LP_TAIL_BEG  = P_CNT_W'(P_SLOT_CYCLES - P_TAIL_CYCLES);
    localparam logic [P_CNT_W-1:0] LP_LAST      = P_CNT_W'(P_SLOT_CYCLES - 1);
    localparam logic               LP_LAST_SLOT = 1'(SLOT_NUM - 1);

    localparam logic [PEER_W-1:0]  LP_RST_TX    = peer_of(LP_TOR_ID, TX_OFS0);
    localparam logic [PEER_W-1:0]  LP_RST_RX    = peer_of(LP_TOR_ID, RX_OFS0);

    slot_state_e        state_q, state_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic               slot_id_q, slot_id_d;
    logic               start_q, start_d;
    logic               guard_q, guard_d;
    logic               tx_en_q, tx_en_d;
    logic [15:0]        epoch_q, epoch_d;
    logic [PEER_W-1:0]  tx_peer_q, tx_peer_d;
    logic [PEER_W-1:0]  rx_peer_q, rx_peer_d;

    // Peers follow the next slot id so they update together with o_slot_id.
    ocs_peer_map u_peer_map (
        .slot_id_i (slot_id_d),
        .tor_id_i  (LP_TOR_ID),
        .tx_peer_o (tx_peer_d),
        .rx_peer_o (rx_peer_d)
    );

    // Priority for a running controller: enable drop, then resync, then slot end.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_id_d = slot_id_q;
        start_d   = 1'b0;
        epoch_d   = epoch_q;

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (bus.i_enable) begin
                state_d   = ST_GUARD;
                slot_id_d = 1'b0;
                start_d   = 1'b1;
            end
        end else if (!bus.i_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (bus.i_resync) begin
            state_d   = ST_GUARD;
            cnt_d     = '0;
            slot_id_d = 1'b0;
            start_d   = 1'b1;
        end else if (cnt_q == LP_LAST) begin
            state_d   = ST_GUARD;
            cnt_d     = '0;
            slot_id_d = ~slot_id_q;
            start_d   = 1'b1;
            if (slot_id_q == LP_LAST_SLOT) begin
                epoch_d = epoch_q + 16'd1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Running phase is a pure function of the next counter value.
        if (state_d != ST_IDLE) begin
            if (cnt_d < LP_GUARD_END) begin
                state_d = ST_GUARD;
            end else if (cnt_d < LP_TAIL_BEG) begin
                state_d = ST_ACTIVE;
            end else begin
                state_d = ST_TAIL;
            end
        end

        guard_d = (state_d == ST_IDLE) || (state_d == ST_GUARD);
        tx_en_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            slot_id_q <= 1'b0;
            start_q   <= 1'b0;
            guard_q   <= 1'b1;
            tx_en_q   <= 1'b0;
            epoch_q   <= '0;
            tx_peer_q <= LP_RST_TX;
            rx_peer_q <= LP_RST_RX;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_id_q <= slot_id_d;
            start_q   <= start_d;
            guard_q   <= guard_d;
            tx_en_q   <= tx_en_d;
            epoch_q   <= epoch_d;
            tx_peer_q <= tx_peer_d;
            rx_peer_q <= rx_peer_d;
        end
    end

    assign bus.o_slot_id    = slot_id_q;
    assign bus.o_slot_start = start_q;
    assign bus.o_guard      = guard_q;
    assign bus.o_tx_en      = tx_en_q;
    assign bus.o_tx_peer    = tx_peer_q;
    assign bus.o_rx_peer    = rx_peer_q;
    assign bus.o_epoch      = epoch_q;

endmodule

// File: tb/tb_ocs_slot_ctrl.sv
// Directed bench for ocs_slot_ctrl with P_TOR_ID=2 and default timing.
// Expected values are hand-derived: slot0 tx/rx peers 1/3, slot1 tx/rx 7/5.
module tb_ocs_slot_ctrl;

    logic i_clk;
    logic i_rst_n;

    int unsigned n_cmp;
    int unsigned n_err;

    ocs_slot_ctrl_if bus ();

    ocs_slot_ctrl #(
        .P_TOR_ID       (2),
        .P_TOR_NUM      (8),
        .P_SLOT_CYCLES  (1000),
        .P_GUARD_CYCLES (50),
        .P_TAIL_CYCLES  (20),
        .P_CNT_W        (16)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n edges; outputs are sampled 1ns after the edge.
    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        i_rst_n      = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_resync = 1'b0;
        run(3);

        chk("rst_slot_id", bus.o_slot_id, 0);
        chk("rst_start",   bus.o_slot_start, 0);
        chk("rst_guard",   bus.o_guard, 1);
        chk("rst_tx_en",   bus.o_tx_en, 0);
        chk("rst_tx_peer", bus.o_tx_peer, 1);
        chk("rst_rx_peer", bus.o_rx_peer, 3);
        chk("rst_epoch",   bus.o_epoch, 0);

        i_rst_n = 1'b1;
        run(7);
        chk("idle_guard", bus.o_guard, 1);

        // Enable -> slot 0, cnt 0
        bus.i_enable = 1'b1;
        run(1);
        chk("en_start",   bus.o_slot_start, 1);
        chk("en_slot_id", bus.o_slot_id, 0);
        chk("en_guard",   bus.o_guard, 1);
        chk("en_tx_en",   bus.o_tx_en, 0);
        chk("en_tx_peer", bus.o_tx_peer, 1);
        chk("en_rx_peer", bus.o_rx_peer, 3);

        run(49);  // cnt 49
        chk("c49_tx_en", bus.o_tx_en, 0);
        chk("c49_guard", bus.o_guard, 1);
        chk("c49_start", bus.o_slot_start, 0);
        run(1);   // cnt 50
        chk("c50_tx_en", bus.o_tx_en, 1);
        chk("c50_guard", bus.o_guard, 0);
        run(929); // cnt 979
        chk("c979_tx_en", bus.o_tx_en, 1);
        run(1);   // cnt 980
        chk("c980_tx_en", bus.o_tx_en, 0);
        chk("c980_guard", bus.o_guard, 0);
        run(19);  // cnt 999
        chk("c999_start", bus.o_slot_start, 0);
        chk("c999_slot",  bus.o_slot_id, 0);
        run(1);   // slot 1, cnt 0 (1000 cycles after first start)
        chk("s1_start",   bus.o_slot_start, 1);
        chk("s1_slot_id", bus.o_slot_id, 1);
        chk("s1_tx_peer", bus.o_tx_peer, 7);
        chk("s1_rx_peer", bus.o_rx_peer, 5);
        chk("s1_epoch",   bus.o_epoch, 0);
        chk("s1_guard",   bus.o_guard, 1);

        run(1000); // slot 0, cnt 0: third start
        chk("s2_start",   bus.o_slot_start, 1);
        chk("s2_slot_id", bus.o_slot_id, 0);
        chk("s2_epoch",   bus.o_epoch, 1);
        chk("s2_tx_peer", bus.o_tx_peer, 1);

        // Resync at cnt 500 of slot 1
        run(1000); // slot 1, cnt 0
        run(500);  // cnt 500
        chk("pre_rs_tx_en", bus.o_tx_en, 1);
        bus.i_resync = 1'b1;
        run(1);
        bus.i_resync = 1'b0;
        chk("rs_slot_id", bus.o_slot_id, 0);
        chk("rs_start",   bus.o_slot_start, 1);
        chk("rs_tx_en",   bus.o_tx_en, 0);
        chk("rs_guard",   bus.o_guard, 1);
        chk("rs_epoch",   bus.o_epoch, 1);
        chk("rs_rx_peer", bus.o_rx_peer, 3);

        // Resync coincident with the slot-1 end
        run(1000); // slot 1, cnt 0
        run(999);  // cnt 999
        bus.i_resync = 1'b1;
        run(1);
        bus.i_resync = 1'b0;
        chk("rsend_slot_id", bus.o_slot_id, 0);
        chk("rsend_start",   bus.o_slot_start, 1);
        chk("rsend_epoch",   bus.o_epoch, 1);

        // Disable during ACTIVE of slot 1: slot id holds
        run(1000); // slot 1, cnt 0
        run(100);
        chk("pre_dis_tx_en", bus.o_tx_en, 1);
        bus.i_enable = 1'b0;
        run(1);
        chk("dis_tx_en",   bus.o_tx_en, 0);
        chk("dis_guard",   bus.o_guard, 1);
        chk("dis_slot_id", bus.o_slot_id, 1);
        chk("dis_tx_peer", bus.o_tx_peer, 7);
        chk("dis_start",   bus.o_slot_start, 0);

        // Resync while idle is ignored
        bus.i_resync = 1'b1;
        run(1);
        bus.i_resync = 1'b0;
        chk("idle_rs_start", bus.o_slot_start, 0);
        chk("idle_rs_slot",  bus.o_slot_id, 1);
        chk("idle_rs_guard", bus.o_guard, 1);

        // Re-enable restarts at slot 0
        bus.i_enable = 1'b1;
        run(1);
        chk("reen_start",   bus.o_slot_start, 1);
        chk("reen_slot_id", bus.o_slot_id, 0);
        chk("reen_tx_peer", bus.o_tx_peer, 1);
        chk("reen_guard",   bus.o_guard, 1);

        // Enable drop beats resync and slot end at cnt 999
        run(999);
        bus.i_enable = 1'b0;
        bus.i_resync = 1'b1;
        run(1);
        bus.i_resync = 1'b0;
        chk("dis_end_start", bus.o_slot_start, 0);
        chk("dis_end_slot",  bus.o_slot_id, 0);
        chk("dis_end_guard", bus.o_guard, 1);
        chk("dis_end_epoch", bus.o_epoch, 1);

        // Reset in the middle of an active window
        bus.i_enable = 1'b1;
        run(1);    // slot 0, cnt 0
        run(1000); // slot 1, cnt 0
        run(60);
        chk("mid_tx_en", bus.o_tx_en, 1);
        chk("mid_epoch", bus.o_epoch, 1);
        i_rst_n = 1'b0;
        run(1);
        chk("mrst_slot_id", bus.o_slot_id, 0);
        chk("mrst_start",   bus.o_slot_start, 0);
        chk("mrst_guard",   bus.o_guard, 1);
        chk("mrst_tx_en",   bus.o_tx_en, 0);
        chk("mrst_tx_peer", bus.o_tx_peer, 1);
        chk("mrst_rx_peer", bus.o_rx_peer, 3);
        chk("mrst_epoch",   bus.o_epoch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
